mult_controller: RTL
====================

# mult_controller

Sequencing FSM for the 32x32 shift-add multiplier datapath: it sits directly upstream of the datapath and drives its mux selects and shift enable. It sequences one load, WIDTH test/shift iterations and a completion pulse, using the multiplier LSB that the datapath returns. It owns the start/done handshake to the requesting logic.

## Interface
- WIDTH, 32: operand width, which is the number of iterations.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset (Reset=0 resets).
- Start  input  1  request; sampled only in IDLE.
- B_LSB  input  1  current multiplier LSB from the datapath (oB_LSB).
- a_sel  output  1  0 loads Data_A into the A register; 1 takes the shifter output.
- b_sel  output  1  0 loads Data_B into the B register; 1 takes the shifter output.
- prod_sel  output  1  0 clears the product register; 1 takes the accumulate path.
- add_sel  output  1  1 writes product+A; 0 holds the product.
- Shift_Enable  output  1  1 shifts A left and B right by one; 0 passes the register value through unchanged (hold).
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle pulse; Prod is valid in this cycle.
- Iter  output  CNT_W  current iteration index (debug).

## Operation
- The design uses one clock. Reset is asynchronous and active-low.
- States are IDLE, LOAD, TEST, SHIFT and DONE.
- The "hold" output set is a_sel=1, b_sel=1, prod_sel=1, add_sel=0, Shift_Enable=0.

**State outputs and transitions**
- **IDLE:** drives the hold set with Busy=0 and Done=0. Goes to LOAD when Start=1; otherwise stays in IDLE.
- **LOAD:** drives a_sel=0, b_sel=0, prod_sel=0, add_sel=0, Shift_Enable=0. Iter is cleared to 0. Always goes to TEST.
- **TEST:** drives the hold set except add_sel=B_LSB, which is a combinational path.
  - The product accumulates A only when the multiplier LSB is 1.
  - Always goes to SHIFT.
- **SHIFT:** drives a_sel=1, b_sel=1, prod_sel=1, add_sel=0, Shift_Enable=1.
  - If Iter==WIDTH-1, goes to DONE.
  - Otherwise Iter is incremented and the FSM goes to TEST.
- **DONE:** drives the hold set with Done=1. Always goes to IDLE.

**Rules**
- All outputs except add_sel are pure Moore decodes of the state register. add_sel is state AND B_LSB.
- Start is ignored in LOAD/TEST/SHIFT/DONE; there is no queuing. Start held high through DONE begins a new operation after one IDLE cycle.
- Iter never exceeds WIDTH-1 and does not wrap within an operation.
- No illegal-state lockup: any unreachable state encoding returns to IDLE on the next edge.

## Timing
- Reset asserted (Reset=0): immediately, without waiting for a clock edge, the FSM goes to IDLE and Iter=0.
  - Outputs then read a_sel=1, b_sel=1, prod_sel=1, add_sel=0, Shift_Enable=0, Busy=0, Done=0.
- Reset mid-operation aborts with no Done pulse; datapath contents are don't-care afterwards.
- Reset deassertion is synchronised by the integrator. The first active edge after release may sample Start.
- Cycle numbering: edge 0 is the edge that samples Start=1 in IDLE.
  - LOAD occupies the cycle after edge 0.
  - TEST for iteration i follows edge 1+2i; SHIFT for iteration i follows edge 2+2i.
  - DONE follows edge 2*WIDTH+1, which is edge 65 for WIDTH=32.
  - IDLE resumes after edge 2*WIDTH+2.
- Busy is high for 2*WIDTH+2 cycles, which is 66.
- Done is high for exactly one cycle per accepted Start.
- B_LSB must be stable in TEST before the closing edge (setup to Clock).

## Test plan
- **Reset values:** drive Reset=0 at an arbitrary time, including mid-SHIFT.
  - Outputs go to the IDLE values immediately, Iter=0 and no Done.
  - After release, the FSM stays in IDLE with Start=0.
- **Basic multiply with the datapath:** Start with A=3, B=5.
  - Done at cycle 65 after edge 0; Prod=15.
  - add_sel is high only in iterations 0 and 2.
- **Extremes:**
  - A=0xFFFFFFFF, B=0xFFFFFFFF gives Prod=0xFFFFFFFE00000001.
  - A=0, B=0x80000000 gives Prod=0, with add_sel high only in iteration 31.
- **Start while busy:** pulse Start at cycles 10 and 40 during an operation.
  - No restart; exactly one Done; Busy continuously high for 66 cycles.
- **Back-to-back:** hold Start=1 continuously.
  - Done pulses are 67 cycles apart, with exactly one IDLE cycle between operations.
  - LOAD asserts prod_sel=0, clearing the previous product.
- **Iteration boundary:** with WIDTH=4 override, A=7, B=9.
  - Iter sequence 0..3; Done after edge 9; Prod=63.

Source files
------------

// File: rtl/mult_controller.sv
// ---------------------------------------------------------------------------
// mult_controller
//
// Sequencing FSM for the shift-add multiplier datapath. One accepted Start
// produces a LOAD cycle, WIDTH TEST/SHIFT iteration pairs and a one-cycle
// DONE pulse, then returns to IDLE. The controller drives the datapath mux
// selects and shift enable and reads back the multiplier LSB.
//
// Parameters
//   WIDTH        operand width = number of iterations
//   CNT_W        iteration counter width, 2**CNT_W must exceed WIDTH
//
// Ports
//   Clock        in   system clock, rising edge
//   Reset        in   asynchronous active-low reset
//   Start        in   operation request, sampled only in IDLE
//   B_LSB        in   current multiplier LSB from the datapath
//   a_sel        out  0 loads Data_A, 1 takes the shifter output
//   b_sel        out  0 loads Data_B, 1 takes the shifter output
//   prod_sel     out  0 clears the product, 1 takes the accumulate path
//   add_sel      out  1 writes product+A, 0 holds the product
//   Shift_Enable out  1 shifts A left / B right, 0 holds
//   Busy         out  high in every state except IDLE
//   Done         out  one-cycle pulse, product valid in this cycle
//   Iter         out  current iteration index (debug)
// ---------------------------------------------------------------------------
module mult_controller #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             B_LSB,
    output logic             a_sel,
    output logic             b_sel,
    output logic             prod_sel,
    output logic             add_sel,
    output logic             Shift_Enable,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Iter
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_TEST  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ITER_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] iter_next;
    logic             last_iter;

    assign last_iter = (Iter == LAST_ITER);

    // State and iteration counter registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            Iter  <= '0;
        end else begin
            state <= state_next;
            Iter  <= iter_next;
        end
    end

    // Next-state and output decode. Every output except add_sel depends only
    // on the state register; add_sel passes B_LSB through in TEST so the
    // product picks up A in the same cycle the LSB is presented.
    always_comb begin
        state_next   = S_IDLE;   // unreachable encodings fall back to IDLE
        iter_next    = Iter;
        a_sel        = 1'b1;
        b_sel        = 1'b1;
        prod_sel     = 1'b1;
        add_sel      = 1'b0;
        Shift_Enable = 1'b0;
        Busy         = 1'b0;
        Done         = 1'b0;

        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_next = S_LOAD;
                    // Clearing here makes Iter read 0 already during LOAD.
                    iter_next  = '0;
                end else begin
                    state_next = S_IDLE;
                end
            end

            S_LOAD: begin
                a_sel      = 1'b0;
                b_sel      = 1'b0;
                prod_sel   = 1'b0;
                Busy       = 1'b1;
                iter_next  = '0;
                state_next = S_TEST;
            end

            S_TEST: begin
                add_sel    = B_LSB;
                Busy       = 1'b1;
                state_next = S_SHIFT;
            end

            S_SHIFT: begin
                Shift_Enable = 1'b1;
                Busy         = 1'b1;
                if (last_iter) begin
                    // Iter stays at WIDTH-1 so it never wraps mid-operation.
                    state_next = S_DONE;
                end else begin
                    iter_next  = Iter + ITER_ONE;
                    state_next = S_TEST;
                end
            end

            S_DONE: begin
                Busy       = 1'b1;
                Done       = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
